// File: rtl/threshold_pkg.sv
// Shared zone encoding and sizing helper for the threshold monitor.
package threshold_pkg;

  // Zone encoding as seen on oState and oEvtCode; value 3 is never produced.
  typedef enum logic [1:0] {
    ZONE_MID  = 2'd0,
    ZONE_HIGH = 2'd1,
    ZONE_LOW  = 2'd2
  } zone_e;

  // Ceiling log2 with a floor of 1 bit, used to size the run counter
  // as clog2(DEBOUNCE+1) so it can hold the full 0..DEBOUNCE range.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/thresh_cmp.sv
// Combinational sample-vs-threshold classifier. When the sample is both
// above iHigh and below iLow (inverted thresholds), "above" wins, so the
// two outputs are never asserted together.
module thresh_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] high,
  input  logic [WIDTH-1:0] low,
  output logic             above,
  output logic             below
);

  // Unsigned compares; below is masked by above to resolve the overlap.
  always_comb begin
    above = (sample > high);
    below = (sample < low) && !(sample > high);
  end

endmodule

// File: rtl/threshold_monitor.sv
// Debounced three-zone threshold monitor.
//
// Handshakes (valid/ready):
//   Sample side: a sample transfers at a rising edge where iValid && oReady.
//     oReady = !oEvtValid || iEvtReady, so a sample is only taken when the
//     event slot is free or being emptied at that same edge.
//   Event side: oEvtValid/oEvtCode are held stable until an edge with
//     iEvtReady = 1; that edge empties the slot unless a new transition is
//     created at the same edge, in which case the slot reloads with it.
//
// State (oState doubles as the FSM state observation point):
//   MID  -> HIGH/LOW after DEBOUNCE consecutive above/below samples
//           (a direction change restarts the run at 1).
//   HIGH -> MID after DEBOUNCE consecutive !above samples.
//   LOW  -> MID after DEBOUNCE consecutive !below samples.
module threshold_monitor
  import threshold_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iSample,
  input  logic [WIDTH-1:0] iHigh,
  input  logic [WIDTH-1:0] iLow,
  input  logic             iClear,
  output logic [1:0]       oState,
  output logic             oEvtValid,
  input  logic             iEvtReady,
  output logic [1:0]       oEvtCode
);

  localparam int            CW  = clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE);
  localparam logic [CW-1:0] ONE = CW'(1);

  zone_e         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;        // 1 = run in MID is "above"
  logic          evt_valid_q, evt_valid_d;
  zone_e         evt_code_q, evt_code_d;

  logic          above, below;
  logic          accept;
  logic          qual;
  logic [CW-1:0] run;
  zone_e         next_zone;

  thresh_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .sample (iSample),
    .high   (iHigh),
    .low    (iLow),
    .above  (above),
    .below  (below)
  );

  // Sample acceptance and event-side readiness.
  always_comb begin
    oReady = !evt_valid_q || iEvtReady;
    accept = iValid && oReady;
  end

  // Next-state: clear has priority, then per-sample run/zone update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    qual        = 1'b0;
    run         = cnt_q;
    next_zone   = ZONE_MID;

    if (evt_valid_q && iEvtReady) evt_valid_d = 1'b0;

    if (iClear) begin
      state_d     = ZONE_MID;
      cnt_d       = '0;
      dir_d       = 1'b1;
      evt_valid_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        ZONE_HIGH: qual = !above;
        ZONE_LOW:  qual = !below;
        default:   qual = above || below;
      endcase

      if (!qual) begin
        run = '0;
      end else if ((state_q == ZONE_MID) && (cnt_q != '0) && (dir_q != above)) begin
        run = ONE;
      end else if (cnt_q < DEB) begin
        run = cnt_q + ONE;
      end

      if ((state_q == ZONE_MID) && qual) dir_d = above;
      cnt_d = run;

      if (qual && (run == DEB)) begin
        if (state_q == ZONE_MID) next_zone = above ? ZONE_HIGH : ZONE_LOW;
        else                     next_zone = ZONE_MID;
        state_d     = next_zone;
        cnt_d       = '0;
        evt_valid_d = 1'b1;
        evt_code_d  = next_zone;
      end
    end
  end

  // State, run counter and event registers with asynchronous reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ZONE_MID;
      cnt_q       <= '0;
      dir_q       <= 1'b1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= ZONE_MID;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
    end
  end

  // Output mapping.
  always_comb begin
    oState    = state_q;
    oEvtValid = evt_valid_q;
    oEvtCode  = evt_code_q;
  end

endmodule

// File: tb/tb_threshold_monitor.sv
// Bench for threshold_monitor: directed scenarios followed by randomized
// traffic, all checked against a behavioural zone/run model.
module tb_threshold_monitor;

  localparam int W = 4;
  localparam int D = 3;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  logic         iValid, oReady, iClear, oEvtValid, iEvtReady;
  logic [W-1:0] iSample, iHigh, iLow;
  logic [1:0]   oState, oEvtCode;

  threshold_monitor #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iValid    (iValid),
    .oReady    (oReady),
    .iSample   (iSample),
    .iHigh     (iHigh),
    .iLow      (iLow),
    .iClear    (iClear),
    .oState    (oState),
    .oEvtValid (oEvtValid),
    .iEvtReady (iEvtReady),
    .oEvtCode  (oEvtCode)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Zones: 0 MID, 1 HIGH, 2 LOW. m_run counts consecutive qualifying samples.
  int m_zone, m_run, m_code;
  bit m_up, m_evt;

  task automatic model_reset();
    m_zone = 0; m_run = 0; m_code = 0; m_up = 1; m_evt = 0;
  endtask

  task automatic model_edge(input bit v, input int s, input int h, input int l,
                            input bit clr, input bit rdy);
    bit ready, acc, is_above, is_below, q;
    ready = !m_evt || rdy;
    acc = v && ready;
    if (m_evt && rdy) m_evt = 0;
    if (clr) begin
      m_zone = 0; m_run = 0; m_up = 1; m_evt = 0;
    end else if (acc) begin
      is_above = (s > h);
      is_below = (s < l) && !is_above;
      if (m_zone == 0) begin
        q = is_above || is_below;
        if (q) begin
          if (m_run > 0 && is_above != m_up) m_run = 1;
          else m_run = (m_run + 1 > D) ? D : m_run + 1;
          m_up = is_above;
        end else m_run = 0;
      end else begin
        q = (m_zone == 1) ? !is_above : !is_below;
        if (q) m_run = (m_run + 1 > D) ? D : m_run + 1;
        else m_run = 0;
      end
      if (q && m_run >= D) begin
        m_zone = (m_zone == 0) ? (m_up ? 1 : 2) : 0;
        m_run = 0;
        m_evt = 1;
        m_code = m_zone;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called away from the clock edge; drives one cycle and checks the result.
  task automatic step(input bit v, input int s, input int h, input int l,
                      input bit clr, input bit rdy);
    iValid = v; iSample = s[W-1:0]; iHigh = h[W-1:0]; iLow = l[W-1:0];
    iClear = clr; iEvtReady = rdy;
    #1;
    check_eq("ready", {31'd0, oReady}, {31'd0, (!m_evt || rdy)});
    model_edge(v, s, h, l, clr, rdy);
    @(posedge iClk);
    #1;
    check_eq("state", {30'd0, oState}, m_zone);
    check_eq("evt_valid", {31'd0, oEvtValid}, {31'd0, m_evt});
    if (m_evt) check_eq("evt_code", {30'd0, oEvtCode}, m_code);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, {30'd0, oState}, 0);
    check_eq({tag, "_evt_valid"}, {31'd0, oEvtValid}, 0);
    check_eq({tag, "_evt_code"}, {30'd0, oEvtCode}, 0);
    check_eq({tag, "_ready"}, {31'd0, oReady}, 1);
  endtask

  // Reset pulse between edges; outputs must react without a clock edge.
  task automatic async_reset();
    #2 iRst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, l;
    iValid = 0; iSample = '0; iHigh = '0; iLow = '0; iClear = 0; iEvtReady = 0;
    model_reset();
    #2 check_reset_values("reset");
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;

    // MID -> HIGH, first sample on first edge after release
    step(1, 11, 10, 5, 0, 1);
    step(1, 12, 10, 5, 0, 1);
    step(1, 13, 10, 5, 0, 1);
    // HIGH: 9, 11 breaks the run, then 9,9,9 -> MID
    step(1, 9, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 1);
    step(1, 9, 10, 5, 0, 1);
    step(1, 9, 10, 5, 0, 1);
    step(1, 9, 10, 5, 0, 1);
    // MID: 11,11 then direction change to 3,3,3 -> LOW
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 1);
    step(1, 3, 10, 5, 0, 1);
    step(1, 3, 10, 5, 0, 0);
    step(1, 3, 10, 5, 0, 0);
    // Event pending, consumer stalled: samples ignored
    step(1, 7, 10, 5, 0, 0);
    step(1, 7, 10, 5, 0, 0);
    step(1, 7, 10, 5, 0, 0);
    // Consumer ready again: ready returns combinationally
    step(1, 7, 10, 5, 0, 1);
    step(1, 7, 10, 5, 0, 1);
    step(1, 7, 10, 5, 0, 1);
    // Clear together with the final qualifying sample
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 1, 1);
    step(0, 11, 10, 5, 0, 1);
    // Async reset with an event pending in HIGH
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 0);
    step(1, 9, 10, 5, 0, 0);
    async_reset();
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 1);
    step(1, 11, 10, 5, 0, 1);
    step(1, 5, 10, 5, 1, 1);
    // Inverted thresholds: above wins
    step(1, 5, 3, 8, 0, 1);
    step(1, 5, 3, 8, 0, 1);
    step(1, 5, 3, 8, 0, 1);
    step(1, 5, 3, 8, 1, 1);

    // Randomized traffic
    h = 10; l = 5;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        h = $urandom_range(0, 15);
        l = $urandom_range(0, 15);
      end
      step($urandom_range(0, 9) < 8, $urandom_range(0, 15), h, l,
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7);
      if (i == 300) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/threshold_monitor.md
THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the sample and threshold width in bits.
REQ-002 The block SHALL have parameter DEBOUNCE, default 3, giving the consecutive qualifying samples needed for a transition; legal range 1..15.
REQ-003 The block SHALL have port iClk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port iRst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port iValid  input  1  a sample is offered on iSample.
REQ-006 The block SHALL have port oReady  output  1  the block accepts the offered sample this cycle.
REQ-007 The block SHALL have port iSample  input  WIDTH  unsigned sample.
REQ-008 The block SHALL have port iHigh  input  WIDTH  unsigned upper threshold, sampled only on accept.
REQ-009 The block SHALL have port iLow  input  WIDTH  unsigned lower threshold, sampled only on accept.
REQ-010 The block SHALL have port iClear  input  1  synchronous clear of state, run counter and pending event.
REQ-011 The block SHALL have port oState  output  2  current zone: 0 = MID, 1 = HIGH, 2 = LOW; 3 is never driven.
REQ-012 The block SHALL have port oEvtValid  output  1  a zone-change event is pending.
REQ-013 The block SHALL have port iEvtReady  input  1  the consumer takes the pending event.
REQ-014 The block SHALL have port oEvtCode  output  2  the zone entered, encoded as in oState.

Function
REQ-015 A sample SHALL be accepted exactly when iValid && oReady at a rising edge.
REQ-016 oReady SHALL equal !oEvtValid || iEvtReady, combinationally.
REQ-017 Per accepted sample: above = iSample > iHigh; below = iSample < iLow; when both are true, above SHALL win.
REQ-018 Qualifying condition per state: MID: above or below, with a direction bit recording which; HIGH: !above; LOW: !below.
REQ-019 The run counter SHALL increment on a qualifying accepted sample, saturating at DEBOUNCE.
REQ-020 The run counter SHALL reset to 0 on a non-qualifying accepted sample.
REQ-021 In MID, a change of direction SHALL restart the run counter at 1.
REQ-022 No accepted sample means no counter change.
REQ-023 On the edge accepting the DEBOUNCE-th consecutive qualifying sample, the block SHALL, at that same edge: change oState (MID to HIGH/LOW by direction; HIGH or LOW to MID); clear the run counter; set oEvtValid = 1 with oEvtCode = new state.
REQ-024 Transition latency SHALL be 1 cycle from the accepting edge to the visible oState and oEvtValid.
REQ-025 HIGH SHALL NOT go directly to LOW, nor LOW to HIGH; MID is always traversed.
REQ-026 oEvtValid and oEvtCode SHALL be held stable until an edge with iEvtReady = 1, at which oEvtValid clears unless a new transition is created at the same edge, in which case it stays 1 with the new code.
REQ-027 iClear SHALL take priority over any accepted sample: at the edge, oState = MID, counter = 0, oEvtValid = 0, and the sample is discarded.
REQ-028 Threshold changes SHALL NOT reset the run counter.
REQ-029 iHigh < iLow is legal, resolved by REQ-017.

Reset
REQ-030 While iRst_n = 0, outputs SHALL be: oState = 0 (MID), oEvtValid = 0, oEvtCode = 0, oReady = 1, run counter = 0, direction = above.
REQ-031 Reset assertion mid-run SHALL discard pending events and partial runs immediately, without waiting for a clock edge.
REQ-032 The first sample SHALL be accepted at the first rising edge after deassertion.

Structure
REQ-033 Package threshold_pkg SHALL hold the zone encoding constants (ZONE_MID, ZONE_HIGH, ZONE_LOW) and the counter width function clog2(DEBOUNCE+1).
REQ-034 The combinational above/below evaluation SHALL be sub-module thresh_cmp (WIDTH parameter, outputs above/below); the FSM, counter and event register stay in the top.

Verification
REQ-035 Scenario: iHigh = 10, iLow = 5, samples 11, 12, 13 with iEvtReady = 1 -> oState = HIGH and oEvtValid pulses with code 1 one cycle after the 13 is accepted.
REQ-036 Scenario: in HIGH, samples 9, 11, 9, 9, 9 -> counter resets at 11, MID is entered after the third consecutive 9, code 0.
REQ-037 Scenario: in MID, samples 11, 11, 3, 3, 3 -> direction restarts at 3 and LOW is entered after the third 3.
REQ-038 Scenario: event pending with iEvtReady = 0 -> oReady = 0, iValid samples are not consumed and oState is unchanged; raising iEvtReady restores oReady in the same cycle.
REQ-039 Scenario: iClear asserted together with the DEBOUNCE-th qualifying sample -> oState = MID and no event; async iRst_n low mid-run -> all outputs reach reset values before the next edge.
REQ-040 Scenario: iHigh = 3, iLow = 8, samples 5, 5, 5 -> HIGH is entered (above wins).
